gearbox_tx_ctrl: RTL and testbench
==================================

// Module: gearbox_tx_ctrl
// PURPOSE
// Sequencer for the 64b/66b TX gearbox. Accepts one 66b block per cycle from the PCS
// encoder over a valid/ready handshake and generates the gearbox sequence count.
// Applies backpressure on the gearbox "full" cycle and substitutes idle blocks on underrun.
// Registers seq/head/data so the gearbox sees aligned inputs. Scope: DATA_W == BLOCK_DATA_W only.
// PARAMETERS
// DATA_W     64                       block payload width (= gearbox DATA_W = BLOCK_DATA_W)
// HEAD_W     2                        sync header width
// SEQ_FULL   DATA_W/HEAD_W            seq value at which the gearbox buffer is full (32)
// SEQ_W      $clog2(DATA_W/HEAD_W+1)  seq width (6)
// IDLE_HEAD  2'b10                    header of substituted idle block (control)
// IDLE_DATA  64'h1E                   payload of idle block: type 0x1E, all-idle control chars
// UCNT_W     16                       underrun counter width
// PORTS
// clk          in   1        clock
// nreset       in   1        synchronous active-low reset
// en_i         in   1        lane enable; rise starts sequencing, fall requests stop
// valid_i      in   1        encoder block valid
// head_i       in   HEAD_W   encoder sync header
// data_i       in   DATA_W   encoder payload
// ready_o      out  1        block accepted when valid_i & ready_o
// seq_o        out  SEQ_W    gearbox seq_i
// head_o       out  HEAD_W   gearbox head_i
// data_o       out  DATA_W   gearbox data_i
// run_o        out  1        gearbox output meaningful (state RUN or DRAIN, registered)
// underrun_o   out  1        sticky: a ready cycle saw valid_i=0; cleared by reset only
// underrun_cnt_o out UCNT_W  saturating count of underrun cycles
// BEHAVIOUR
// - State IDLE/RUN/DRAIN; internal counter cnt (SEQ_W) = seq of the next gearbox cycle.
// - Reset (nreset=0 at posedge): state=IDLE, cnt=0, seq_o=0, head_o=IDLE_HEAD,
//   data_o=IDLE_DATA, run_o=0, underrun_o=0, underrun_cnt_o=0. Overrides all else.
// - ready_o (combinational) = (state!=IDLE) & (cnt!=SEQ_FULL). Independent of valid_i.
// - IDLE: ready_o=0, cnt held 0, outputs held at reset values. en_i=1 -> RUN next cycle.
// - RUN/DRAIN, each posedge: seq_o<=cnt; run_o<=1; cnt<=(cnt==SEQ_FULL)?0:cnt+1.
//   valid_i&ready_o: head_o<=head_i, data_o<=data_i.
//   Otherwise: head_o<=IDLE_HEAD, data_o<=IDLE_DATA. This includes the full cycle, where
//   the gearbox ignores the data.
// - Latency: accepted block appears on head_o/data_o exactly 1 cycle later, seq_o aligned.
// - Underrun: ready_o=1 & valid_i=0 -> underrun_o<=1, underrun_cnt_o += 1, saturating at
//   all-ones. The full cycle (cnt==SEQ_FULL) is never an underrun.
// - Period: 33 cycles per cnt wrap (0..32); exactly 32 blocks accepted per 33 cycles.
// - RUN & en_i=0 -> DRAIN. DRAIN keeps sequencing; en_i=1 in DRAIN -> RUN.
//   DRAIN & cnt==SEQ_FULL -> IDLE after that edge (cnt->0). The gearbox always stops
//   at a wrap boundary with its buffer empty.
// - en_i=1 & cnt==SEQ_FULL in RUN: no special action, cnt wraps normally.
// - Reset mid-operation: immediate return to reset values. No partial drain.
// - run_o falls on the edge entering IDLE. seq_o=0 and idle outputs hold from then on.
// TESTING
// - Reset, en_i=1, valid_i=1 always: ready_o low exactly every 33rd cycle, at cnt=32.
//   seq_o steps 0..32 and wraps. 32 blocks accepted per period, 0 underruns.
// - Incrementing data_i: each accepted word appears on data_o 1 cycle later with seq_o=k.
//   The word accepted when cnt=k carries seq_o=k.
// - valid_i=0 for 3 ready cycles at cnt=5..7: data_o=64'h1E, head_o=2'b10 at seq 5..7.
//   underrun_o=1, underrun_cnt_o=3.
// - en_i drops at cnt=10: state DRAIN, ready_o=1 through cnt=31, 0 at cnt=32.
//   IDLE next cycle, run_o=0, seq_o=0.
// - en_i drops at cnt=10 and returns at cnt=20: state RUN, no stop, period unchanged.
// - Underrun count preset near max via long valid_i=0 run: underrun_cnt_o saturates at 16'hFFFF.
//   nreset=0 mid-period: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/gearbox_tx_ctrl.sv
// Sequencer for the 64b/66b TX gearbox: takes one 66b block per cycle from the PCS encoder,
// drives the gearbox seq count, stalls on the full cycle and fills underruns with idle blocks.
module gearbox_tx_ctrl #(
    parameter int               DATA_W    = 64,
    parameter int               HEAD_W    = 2,
    parameter int               SEQ_FULL  = DATA_W / HEAD_W,
    parameter int               SEQ_W     = $clog2(DATA_W / HEAD_W + 1),
    parameter logic [HEAD_W-1:0] IDLE_HEAD = 2'b10,
    parameter logic [DATA_W-1:0] IDLE_DATA = 64'h1E,
    parameter int               UCNT_W    = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              run_o,
    output logic              underrun_o,
    output logic [UCNT_W-1:0] underrun_cnt_o,
    output logic [1:0]        state_o
);

    // Handshake: a block transfers on any posedge where valid_i & ready_o; ready_o never
    // depends on valid_i, and valid_i low while ready_o is high counts as an underrun.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [SEQ_W-1:0] SEQ_FULL_C = SEQ_W'(SEQ_FULL);

    state_t           state;
    state_t           state_nx;
    logic [SEQ_W-1:0] cnt;
    logic             active;
    logic             full;

    assign active  = (state != ST_IDLE);
    assign full    = (cnt == SEQ_FULL_C);
    assign ready_o = active & ~full;
    assign state_o = state;

    // A draining lane only stops at the wrap boundary so the gearbox buffer ends empty.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (en_i) state_nx = ST_RUN;
            ST_RUN:   if (!en_i) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (en_i)      state_nx = ST_RUN;
                else if (full) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            seq_o          <= '0;
            head_o         <= IDLE_HEAD;
            data_o         <= IDLE_DATA;
            run_o          <= 1'b0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            state <= state_nx;
            if (active) begin
                if (state_nx == ST_IDLE) begin
                    cnt    <= '0;
                    seq_o  <= '0;
                    run_o  <= 1'b0;
                    head_o <= IDLE_HEAD;
                    data_o <= IDLE_DATA;
                end else begin
                    seq_o <= cnt;
                    run_o <= 1'b1;
                    cnt   <= full ? '0 : cnt + SEQ_W'(1);
                    if (valid_i && ready_o) begin
                        head_o <= head_i;
                        data_o <= data_i;
                    end else begin
                        head_o <= IDLE_HEAD;
                        data_o <= IDLE_DATA;
                    end
                end
                if (ready_o && !valid_i) begin
                    underrun_o <= 1'b1;
                    if (underrun_cnt_o != '1) underrun_cnt_o <= underrun_cnt_o + UCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gearbox_tx_ctrl.sv
// Randomized bench for gearbox_tx_ctrl: a period-level lane model predicts every output
// cycle into a queue, and a monitor pops and compares one entry after each posedge.
module tb_gearbox_tx_ctrl;

    localparam int FULL = 32;
    localparam logic [1:0]  IDLE_H = 2'b10;
    localparam logic [63:0] IDLE_D = 64'h1E;

    logic        clk = 1'b0;
    logic        nreset;
    logic        en_i;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic [5:0]  seq_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        run_o;
    logic        underrun_o;
    logic [15:0] underrun_cnt_o;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;

    // expected {seq, head, data, run, underrun, underrun_cnt}
    logic [89:0] exp_q[$];

    // Lane model: lane_on = sequencing, stop_req = enable was low at the previous edge.
    bit          lane_on  = 1'b0;
    bit          stop_req = 1'b0;
    int          pos      = 0;
    int          m_seq    = 0;
    logic [1:0]  m_head   = IDLE_H;
    logic [63:0] m_data   = IDLE_D;
    bit          m_run    = 1'b0;
    bit          m_uf     = 1'b0;
    int          m_ucnt   = 0;

    always #5 clk = ~clk;

    gearbox_tx_ctrl dut (
        .clk            (clk),
        .nreset         (nreset),
        .en_i           (en_i),
        .valid_i        (valid_i),
        .head_i         (head_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .seq_o          (seq_o),
        .head_o         (head_o),
        .data_o         (data_o),
        .run_o          (run_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o),
        .state_o        (state_o)
    );

    task automatic model_step();
        bit slot_open;
        bit took;
        if (!nreset) begin
            lane_on = 0; stop_req = 0; pos = 0; m_seq = 0;
            m_head = IDLE_H; m_data = IDLE_D; m_run = 0; m_uf = 0; m_ucnt = 0;
        end else if (!lane_on) begin
            if (en_i) begin
                lane_on  = 1;
                stop_req = 0;
            end
        end else begin
            slot_open = (pos != FULL);
            took      = slot_open && valid_i;
            if (slot_open && !valid_i) begin
                m_uf = 1;
                if (m_ucnt < 65535) m_ucnt = m_ucnt + 1;
            end
            if (stop_req && !en_i && pos == FULL) begin
                lane_on = 0; pos = 0; m_seq = 0; m_run = 0;
                m_head = IDLE_H; m_data = IDLE_D;
            end else begin
                m_seq    = pos;
                m_run    = 1;
                m_head   = took ? head_i : IDLE_H;
                m_data   = took ? data_i : IDLE_D;
                pos      = (pos + 1) % (FULL + 1);
                stop_req = !en_i;
            end
        end
        exp_q.push_back({6'(m_seq), m_head, m_data, m_run, m_uf, 16'(m_ucnt)});
    endtask

    task automatic drive_cycle(input bit en, input bit v, input bit rst_n);
        bit exp_rdy;
        @(negedge clk);
        nreset  = rst_n;
        en_i    = en;
        valid_i = v;
        head_i  = 2'($urandom_range(0, 3));
        data_i  = {$urandom, $urandom};
        #1;
        exp_rdy = lane_on && (pos != FULL);
        tests++;
        if (ready_o !== exp_rdy) begin
            fails++;
            $display("FAIL ready pos=%0d got=%b want=%b", pos, ready_o, exp_rdy);
        end
        model_step();
    endtask

    always @(posedge clk) begin
        logic [89:0] e;
        logic [89:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {seq_o, head_o, data_o, run_o, underrun_o, underrun_cnt_o};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL out got seq=%0d head=%b data=%h run=%b uf=%b ucnt=%0d want seq=%0d head=%b data=%h run=%b uf=%b ucnt=%0d",
                         a[89:84], a[83:82], a[81:18], a[17], a[16], a[15:0],
                         e[89:84], e[83:82], e[81:18], e[17], e[16], e[15:0]);
            end
        end
    end

    task automatic reset_lane();
        repeat (2) drive_cycle(0, 0, 0);
    endtask

    task automatic run_until(input int target, input bit en, input bit v);
        int guard = 0;
        while (pos != target && guard < 100) begin
            drive_cycle(en, v, 1);
            guard++;
        end
        tests++;
        if (pos != target) begin
            fails++;
            $display("FAIL reach_pos got=%0d want=%0d", pos, target);
        end
    endtask

    initial begin
        nreset = 0; en_i = 0; valid_i = 0; head_i = '0; data_i = '0;
        @(posedge clk);
        reset_lane();

        // Steady stream, valid always high: three full periods.
        repeat (100) drive_cycle(1, 1, 1);

        // Random valid pattern.
        repeat (200) drive_cycle(1, ($urandom_range(0, 3) != 0), 1);

        // Three underruns at seq 5..7 from a fresh reset.
        reset_lane();
        drive_cycle(1, 1, 1);
        run_until(5, 1, 1);
        repeat (3) drive_cycle(1, 0, 1);
        repeat (30) drive_cycle(1, 1, 1);
        tests++;
        if (underrun_cnt_o !== 16'd3) begin
            fails++;
            $display("FAIL ucnt3 got=%0d want=3", underrun_cnt_o);
        end

        // Enable low at seq 10, back at 20: no stop.
        run_until(10, 1, 1);
        run_until(20, 0, 1);
        repeat (40) drive_cycle(1, ($urandom_range(0, 1) == 1), 1);

        // Enable low at seq 10 until the lane stops, then stay idle.
        run_until(10, 1, 1);
        repeat (40) drive_cycle(0, 1, 1);
        tests++;
        if (run_o !== 1'b0 || seq_o !== 6'd0) begin
            fails++;
            $display("FAIL stopped got run=%b seq=%0d want run=0 seq=0", run_o, seq_o);
        end

        // Random enable and valid, including restarts from idle.
        repeat (400) drive_cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), 1);

        // Saturate the underrun counter with a long starved run.
        reset_lane();
        repeat (2050 * 33) drive_cycle(1, 0, 1);
        tests++;
        if (underrun_cnt_o !== 16'hFFFF) begin
            fails++;
            $display("FAIL ucnt_sat got=%h want=ffff", underrun_cnt_o);
        end

        // Reset in the middle of a period.
        repeat (17) drive_cycle(1, 1, 1);
        drive_cycle(1, 1, 0);
        repeat (5) drive_cycle(0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
